// File: rtl/execute_muldiv_unit_if.sv
// Execute-stage handshake bundle for the iterative RV32M multiply/divide unit.
// The slave side is the unit itself; the master side is the pipeline control around it.
interface execute_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  // Handshake: start is held high while stall_req is high. The result is taken
  // in the cycle where done=1 and stall=0 (the DONE->IDLE edge advances EX/MEM).
  logic                  stall;
  logic                  flush;
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic [DATA_WIDTH-1:0] result;
  logic                  done;
  logic                  busy;
  logic                  stall_req;
  logic [1:0]            state_dbg;

  modport slave (
    input  stall, flush, start, op, src_a, src_b,
    output result, done, busy, stall_req, state_dbg
  );

  modport master (
    output stall, flush, start, op, src_a, src_b,
    input  result, done, busy, stall_req, state_dbg
  );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Radix-2 sequential RV32M multiply/divide for the execute stage: shift-add multiply,
// restoring divide, one bit per cycle over operand magnitudes, sign fixed at the end.
module execute_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  execute_muldiv_unit_if.slave  mdu
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic [2:0]     r_op;
  logic           r_neg;
  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_prod;
  logic [W-1:0]   r_mplier;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_dvsr;
  logic [W-1:0]   r_result;
  logic           r_done;
  logic           r_busy;

  logic           w_is_div;
  logic           w_a_signed;
  logic           w_b_signed;
  logic           w_neg_a;
  logic           w_neg_b;
  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;
  logic           w_neg;
  logic           w_div_zero;
  logic           w_ovf;
  logic           w_fast;
  logic [W-1:0]   w_fast_result;
  logic [2*W-1:0] w_prod_next;
  logic [2*W-1:0] w_prod_fin;
  logic [W:0]     w_rem_shift;
  logic [W:0]     w_rem_diff;
  logic [W-1:0]   w_rem_next;
  logic [W-1:0]   w_quo_next;
  logic [W-1:0]   w_quo_fin;
  logic [W-1:0]   w_rem_fin;
  logic [W-1:0]   w_calc_result;

  // Operand signedness from funct3: MUL/MULH/MULHSU take a signed rs1, MUL/MULH a signed rs2.
  assign w_is_div   = mdu.op[2];
  assign w_a_signed = w_is_div ? ~mdu.op[0] : (mdu.op[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~mdu.op[0] : ~mdu.op[1];
  assign w_neg_a    = w_a_signed & mdu.src_a[W-1];
  assign w_neg_b    = w_b_signed & mdu.src_b[W-1];
  assign w_mag_a    = w_neg_a ? -mdu.src_a : mdu.src_a;
  assign w_mag_b    = w_neg_b ? -mdu.src_b : mdu.src_b;
  assign w_neg      = (w_is_div && mdu.op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

  assign w_div_zero = w_is_div && (mdu.src_b == '0);
  assign w_ovf      = w_is_div && !mdu.op[0] && (mdu.src_a == {1'b1, {(W-1){1'b0}}})
                      && (mdu.src_b == {W{1'b1}});
  assign w_fast     = w_div_zero || w_ovf;
  assign w_fast_result = w_div_zero ? (mdu.op[1] ? mdu.src_a : {W{1'b1}})
                                    : (mdu.op[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}});

  assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign w_prod_fin  = r_neg ? -w_prod_next : w_prod_next;

  // Restoring step: the remainder stays below the divisor, so W bits hold it between steps.
  assign w_rem_shift = {r_rem, r_quo[W-1]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_dvsr};
  assign w_rem_next  = w_rem_diff[W] ? w_rem_shift[W-1:0] : w_rem_diff[W-1:0];
  assign w_quo_next  = {r_quo[W-2:0], ~w_rem_diff[W]};
  assign w_quo_fin   = r_neg ? -w_quo_next : w_quo_next;
  assign w_rem_fin   = r_neg ? -w_rem_next : w_rem_next;

  assign w_calc_result = !r_op[2] ? ((r_op[1:0] == 2'b00) ? w_prod_fin[W-1:0] : w_prod_fin[2*W-1:W])
                                  : (r_op[1] ? w_rem_fin : w_quo_fin);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (mdu.flush) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mdu.start) begin
            r_op     <= mdu.op;
            r_neg    <= w_neg;
            r_mcand  <= {{W{1'b0}}, w_mag_a};
            r_prod   <= '0;
            r_mplier <= w_mag_b;
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_dvsr   <= w_mag_b;
            r_count  <= '0;
            if (w_fast) begin
              r_result <= w_fast_result;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_prod   <= w_prod_next;
          r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[W-1:1]};
          r_rem    <= w_rem_next;
          r_quo    <= w_quo_next;
          r_count  <= r_count + CW'(1);
          if (r_count == CW'(W-1)) begin
            r_result <= w_calc_result;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!mdu.stall) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mdu.stall_req = !reset && (((r_state == S_IDLE) && mdu.start && !mdu.flush)
                                    || (r_state == S_CALC));
  assign mdu.result    = r_result;
  assign mdu.done      = r_done;
  assign mdu.busy      = r_busy;
  assign mdu.state_dbg = r_state;
endmodule
